// File: rtl/tts_pkg.sv
//------------------------------------------------------------------------------
// tts_pkg : shared types and limits for the truth-table sweeper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tts_pkg;

  localparam int TTS_MAX_N      = 16;
  localparam int TTS_MAX_SETTLE = 15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } tts_state_e;

  // Counter preload so that WAIT lasts exactly `settle` cycles.
  function automatic logic [3:0] tts_settle_load(input int settle);
    return (settle > 0) ? 4'(settle - 1) : 4'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tts_settle_cnt.sv
//------------------------------------------------------------------------------
// tts_settle_cnt : 4-bit down-counter with load and terminal pulse
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tts_settle_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       tc
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign tc = en && (cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
//------------------------------------------------------------------------------
// truth_table_sweeper : exhaustive equivalence check of two 1-bit functions
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            fa,
  input  logic            fb,
  output logic            busy,
  output logic            done,
  output logic            match,
  output logic [N_IN:0]   mism_cnt,
  output logic [N_IN-1:0] first_bad,
  output logic            first_bad_vld
);

  generate
    if (N_IN < 1 || N_IN > TTS_MAX_N) begin : g_bad_n_in
      $error("truth_table_sweeper: N_IN out of range 1..16");
    end
    if (SETTLE < 0 || SETTLE > TTS_MAX_SETTLE) begin : g_bad_settle
      $error("truth_table_sweeper: SETTLE out of range 0..15");
    end
  endgenerate

  localparam logic [N_IN-1:0] VEC_ONES   = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_LD  = tts_settle_load(SETTLE);
  localparam tts_state_e      VEC_ENTRY  = (SETTLE > 0) ? S_WAIT : S_SAMPLE;

  tts_state_e    state;
  logic          settle_tc;
  logic          diff;
  logic [N_IN:0] cnt_inc;

  // The counter is preloaded whenever we are outside WAIT, so each entry
  // into WAIT starts a fresh settle interval without extra control.
  tts_settle_cnt u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (state != S_WAIT),
    .en       (state == S_WAIT),
    .load_val (SETTLE_LD),
    .tc       (settle_tc)
  );

  assign diff    = fa ^ fb;
  assign cnt_inc = mism_cnt + {{N_IN{1'b0}}, diff};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      vec           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      match         <= 1'b0;
      mism_cnt      <= '0;
      first_bad     <= '0;
      first_bad_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec           <= '0;
            mism_cnt      <= '0;
            first_bad     <= '0;
            first_bad_vld <= 1'b0;
            match         <= 1'b0;
            busy          <= 1'b1;
            state         <= VEC_ENTRY;
          end
        end
        S_WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (settle_tc) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            mism_cnt <= cnt_inc;
            if (diff && !first_bad_vld) begin
              first_bad     <= vec;
              first_bad_vld <= 1'b1;
            end
            // vec stops at all ones rather than wrapping back to zero.
            if (vec == VEC_ONES) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              match <= (cnt_inc == '0);
              state <= S_DONE;
            end else begin
              vec   <= vec + 1'b1;
              state <= VEC_ENTRY;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
//------------------------------------------------------------------------------
// tb_truth_table_sweeper : directed self-checking bench for truth_table_sweeper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [3:0] vec4;
  logic       fa4, fb4;
  logic       busy4, done4, match4, fbv4;
  logic [4:0] mism4;
  logic [3:0] first_bad4;

  logic       start1 = 1'b0;
  logic       abort1 = 1'b0;
  logic [0:0] vec1;
  logic       busy1, done1, match1, fbv1;
  logic [1:0] mism1;
  logic [0:0] first_bad1;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int vec_err;
  int done_seen;

  always #5 clk = ~clk;

  // f = ab + cd, built once from NAND gates and once from NOR gates.
  function automatic logic f_nand(input logic [3:0] v);
    logic n1, n2;
    n1 = ~(v[3] & v[2]);
    n2 = ~(v[1] & v[0]);
    return ~(n1 & n2);
  endfunction

  function automatic logic f_nor(input logic [3:0] v);
    logic m1, m2, m3, m4;
    m1 = ~(v[3] | v[1]);
    m2 = ~(v[3] | v[0]);
    m3 = ~(v[2] | v[1]);
    m4 = ~(v[2] | v[0]);
    return ~(m1 | m2 | m3 | m4);
  endfunction

  assign fa4 = f_nand(vec4);
  assign fb4 = (mode == 2'd0) ? f_nor(vec4) :
               (mode == 2'd1) ? (fa4 ^ (vec4 == 4'hA)) : ~fa4;

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec4),
    .fa(fa4), .fb(fb4), .busy(busy4), .done(done4), .match(match4),
    .mism_cnt(mism4), .first_bad(first_bad4), .first_bad_vld(fbv4)
  );

  truth_table_sweeper #(.N_IN(1), .SETTLE(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .vec(vec1),
    .fa(vec1[0]), .fb(vec1[0]), .busy(busy1), .done(done1), .match(match1),
    .mism_cnt(mism1), .first_bad(first_bad1), .first_bad_vld(fbv1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge just after the start edge; returns the cycle
  // count to done and the number of wrong vec values seen on the way.
  task automatic run_sweep4(output int n, output int errs);
    n = 0;
    errs = 0;
    while (done4 !== 1'b1 && n < 80) begin
      if (n < 32 && vec4 !== 4'(n / 2)) errs++;
      tick();
      n++;
    end
  endtask

  task automatic start4();
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(negedge clk);
    check("rst_vec", 32'(vec4), 32'h0);
    check("rst_busy", 32'(busy4), 32'h0);
    check("rst_done", 32'(done4), 32'h0);
    check("rst_match", 32'(match4), 32'h0);
    check("rst_mism", 32'(mism4), 32'h0);
    check("rst_first_bad", 32'(first_bad4), 32'h0);
    check("rst_fbv", 32'(fbv4), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Equivalent NAND/NOR implementations
    mode = 2'd0;
    start4();
    check("eq_busy_t0", 32'(busy4), 32'h1);
    check("eq_vec_t0", 32'(vec4), 32'h0);
    run_sweep4(cyc, vec_err);
    check("eq_done_latency", 32'(cyc), 32'd32);
    check("eq_vec_seq_err", 32'(vec_err), 32'd0);
    check("eq_match", 32'(match4), 32'h1);
    check("eq_mism", 32'(mism4), 32'h0);
    check("eq_fbv", 32'(fbv4), 32'h0);
    check("eq_busy_done", 32'(busy4), 32'h0);
    check("eq_vec_hold", 32'(vec4), 32'hF);
    tick();
    check("eq_done_pulse", 32'(done4), 32'h0);
    check("eq_match_hold", 32'(match4), 32'h1);

    // Single mismatch at 4'hA
    mode = 2'd1;
    start4();
    check("one_match_clr", 32'(match4), 32'h0);
    run_sweep4(cyc, vec_err);
    check("one_done_latency", 32'(cyc), 32'd32);
    check("one_mism", 32'(mism4), 32'h1);
    check("one_first_bad", 32'(first_bad4), 32'hA);
    check("one_fbv", 32'(fbv4), 32'h1);
    check("one_match", 32'(match4), 32'h0);

    // Every vector mismatches
    mode = 2'd2;
    start4();
    run_sweep4(cyc, vec_err);
    check("all_done_latency", 32'(cyc), 32'd32);
    check("all_mism", 32'(mism4), 32'h10);
    check("all_first_bad", 32'(first_bad4), 32'h0);
    check("all_match", 32'(match4), 32'h0);

    // Abort at the edge 10 cycles after start (SAMPLE of vec 4)
    start4();
    for (int i = 0; i < 9; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy4), 32'h0);
    check("abort_mism", 32'(mism4), 32'h4);
    check("abort_fbv", 32'(fbv4), 32'h1);
    check("abort_first_bad", 32'(first_bad4), 32'h0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done4 === 1'b1) done_seen++;
      tick();
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_match", 32'(match4), 32'h0);
    check("abort_mism_hold", 32'(mism4), 32'h4);

    // Reset mid-sweep
    start4();
    for (int i = 0; i < 6; i++) tick();
    check("mid_mism_pre", 32'(mism4), 32'h3);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy4), 32'h0);
    check("mid_rst_vec", 32'(vec4), 32'h0);
    check("mid_rst_mism", 32'(mism4), 32'h0);
    check("mid_rst_fbv", 32'(fbv4), 32'h0);
    check("mid_rst_done", 32'(done4), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // start held through a sweep and through DONE
    mode = 2'd1;
    start = 1'b1;
    tick();
    run_sweep4(cyc, vec_err);
    check("held_done_latency", 32'(cyc), 32'd32);
    check("held_vec_seq_err", 32'(vec_err), 32'd0);
    check("held_mism", 32'(mism4), 32'h1);
    tick();
    check("held_idle_busy", 32'(busy4), 32'h0);
    check("held_idle_mism", 32'(mism4), 32'h1);
    tick();
    start = 1'b0;
    mode = 2'd0;
    check("restart_busy", 32'(busy4), 32'h1);
    check("restart_vec", 32'(vec4), 32'h0);
    check("restart_mism", 32'(mism4), 32'h0);
    check("restart_fbv", 32'(fbv4), 32'h0);
    check("restart_first_bad", 32'(first_bad4), 32'h0);
    run_sweep4(cyc, vec_err);
    check("restart_done_latency", 32'(cyc), 32'd32);
    check("restart_match", 32'(match4), 32'h1);

    // N_IN=1, SETTLE=0
    @(negedge clk);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("n1_busy_t0", 32'(busy1), 32'h1);
    check("n1_vec_0", 32'(vec1), 32'h0);
    check("n1_done_early0", 32'(done1), 32'h0);
    tick();
    check("n1_vec_1", 32'(vec1), 32'h1);
    check("n1_done_early1", 32'(done1), 32'h0);
    tick();
    check("n1_done", 32'(done1), 32'h1);
    check("n1_match", 32'(match1), 32'h1);
    check("n1_busy_end", 32'(busy1), 32'h0);
    check("n1_vec_hold", 32'(vec1), 32'h1);
    check("n1_mism", 32'(mism1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential exhaustive-equivalence engine for small combinational blocks. On `start` it steps an N-bit input vector through all 2^N combinations, waits a programmable settle time per vector, and compares two single-bit implementations of the same function (e.g. NAND-only vs NOR-only realisations). It reports pass/fail, mismatch count and first failing vector. It sits beside gate-level function blocks as a reusable on-chip or in-bench checker, replacing hand-written 16-step stimulus sequences.

## Interface
- `N_IN`, 4, number of function inputs; legal 1..16.
- `SETTLE`, 1, idle cycles after each vector change before sampling; legal 0..15.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a sweep; honoured only in IDLE.
- `abort` in 1: cancel a running sweep.
- `vec` out N_IN: vector driven to both implementations.
- `fa` in 1: output of implementation A.
- `fb` in 1: output of implementation B.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at sweep completion.
- `match` out 1: 1 when the completed sweep saw zero mismatches.
- `mism_cnt` out N_IN+1: mismatch count for the current or last sweep.
- `first_bad` out N_IN: first vector with `fa != fb`.
- `first_bad_vld` out 1: `first_bad` holds a captured vector.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE + `start`:
  - clear `vec`, `mism_cnt`, `first_bad`, `first_bad_vld` and `match`;
  - set `busy`;
  - go to WAIT if SETTLE>0, else go to SAMPLE.
- WAIT: count SETTLE cycles with `vec` stable, then go to SAMPLE.
- SAMPLE, one cycle:
  - if `fa != fb`, increment `mism_cnt`;
  - if `fa != fb` and `first_bad_vld`=0, load `first_bad`=`vec` and set `first_bad_vld`;
  - if `vec` is all ones, go to DONE;
  - otherwise increment `vec` and go to WAIT (or SAMPLE when SETTLE=0).
- DONE, one cycle:
  - `done`=1, `busy`=0;
  - `match` = (`mism_cnt`==0), using the count after the final sample;
  - then go to IDLE.
- Terminal detection is by compare against all ones. `vec` never wraps; it holds all ones after the sweep until the next `start`.
- `mism_cnt` is N_IN+1 bits so it can reach 2^N_IN without overflow.
- `start` is ignored in WAIT, SAMPLE and DONE. No queuing.
- `abort` in WAIT or SAMPLE:
  - go to IDLE on the next edge with `busy`=0;
  - no `done` pulse, `match` stays 0;
  - partial `mism_cnt` and `first_bad` are held;
  - a mismatch in the abort cycle is not counted.
- `abort` has priority over `start` and over the SAMPLE update. `abort` in IDLE or DONE has no effect.
- Reset mid-sweep: all outputs return to reset values immediately, state goes to IDLE and no `done` is produced.

## Timing
- Reset values: `vec`=0, `busy`=0, `done`=0, `match`=0, `mism_cnt`=0, `first_bad`=0, `first_bad_vld`=0.
- `start` sampled high at edge t0: `busy`=1 and `vec`=0 from t0.
- Each vector is held for SETTLE+1 cycles. `fa` and `fb` are registered at the closing edge of each vector's SAMPLE cycle.
- `done`=1 and `busy`=0 in the cycle after edge t0 + 2^N_IN·(SETTLE+1).
- `match`, `mism_cnt` and `first_bad` are valid from that cycle until the next accepted `start`.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package `tts_pkg`:
  - state enum typedef (IDLE, WAIT, SAMPLE, DONE);
  - `TTS_MAX_N`=16;
  - `TTS_MAX_SETTLE`=15.
- Sub-module `tts_settle_cnt`: 4-bit down-counter with load and terminal pulse, used by WAIT.
- Elaboration-time checks reject N_IN or SETTLE values outside their legal ranges.

## Test plan
- N_IN=4, SETTLE=1, `fa`/`fb` driven by NAND-form and NOR-form realisations of the same 4-input function -> `done` 32 cycles after `start`, `match`=1, `mism_cnt`=0, `first_bad_vld`=0.
- `fb` = `fa` XOR (`vec`==4'hA) -> `mism_cnt`=1, `first_bad`=4'hA, `match`=0.
- `fb` = ~`fa` -> `mism_cnt`=16 (5'h10), `first_bad`=0.
- `abort` pulsed 10 cycles after `start` -> `busy`=0 next cycle, no `done`, `mism_cnt` holds partial value.
- `rst` mid-sweep, then `start` held high during the sweep, then a second `start` right after `done` -> reset values immediately, the held `start` is ignored, the second sweep restarts at `vec`=0 with counters cleared.
- N_IN=1, SETTLE=0 -> `done` 2 cycles after `start`, `vec` sequence 0,1.
